// File: rtl/time_set_ctrl.sv
// time_set_ctrl: run/set-mode controller for the century clock.
// Makes the 1 Hz tick in RUN. In the SET states it stops the tick and steers
// increment presses, with auto-repeat, to the selected field counter. It also
// drives the blink phase for the selected field.
// Ports:
//   clk_50MHz, rst_n         board clock, async active-low reset
//   key_mode_n, key_inc_n    raw active-low keys (already debounced, asynchronous)
//   tick_1Hz                 one-cycle seconds increment pulse (RUN only)
//   clr_sec                  one-cycle seconds clear on RUN -> SET_MIN
//   inc_*_o                  one-cycle manual increment pulses, one per field
//   set_field                0=RUN 1=MIN 2=HOUR 3=DAY 4=MON 5=YEAR
//   blink                    blanking phase for the selected field
module time_set_ctrl #(
  parameter int unsigned DIV_1HZ    = 50_000_000,
  parameter int unsigned REPEAT_DLY = 25_000_000,
  parameter int unsigned REPEAT_PER = 5_000_000,
  parameter int unsigned BLINK_HALF = 12_500_000
) (
  input  logic       clk_50MHz,
  input  logic       rst_n,
  input  logic       key_mode_n,
  input  logic       key_inc_n,
  output logic       tick_1Hz,
  output logic       clr_sec,
  output logic       inc_min_o,
  output logic       inc_hour_o,
  output logic       inc_day_o,
  output logic       inc_mon_o,
  output logic       inc_year_o,
  output logic [2:0] set_field,
  output logic       blink
);

  localparam int unsigned DIV_W   = (DIV_1HZ > 1)    ? $clog2(DIV_1HZ)    : 1;
  localparam int unsigned DLY_W   = (REPEAT_DLY > 1) ? $clog2(REPEAT_DLY) : 1;
  localparam int unsigned PER_W   = (REPEAT_PER > 1) ? $clog2(REPEAT_PER) : 1;
  localparam int unsigned HOLD_W  = (DLY_W > PER_W) ? DLY_W : PER_W;
  localparam int unsigned BLINK_W = (BLINK_HALF > 1) ? $clog2(BLINK_HALF) : 1;

  typedef enum logic [2:0] {
    S_RUN  = 3'd0,
    S_MIN  = 3'd1,
    S_HOUR = 3'd2,
    S_DAY  = 3'd3,
    S_MON  = 3'd4,
    S_YEAR = 3'd5
  } state_t;

  state_t              state;
  state_t              state_nxt;
  logic                mode_s1, mode_s2, mode_d;
  logic                inc_s1, inc_s2, inc_d;
  logic [DIV_W-1:0]    div_cnt;
  logic [DIV_W-1:0]    div_nxt;
  logic [HOLD_W-1:0]   hold_cnt;
  logic                hold_act;
  logic                rep_phase;
  logic [BLINK_W-1:0]  blink_cnt;
  logic                mode_press_c;
  logic                inc_press_c;
  logic                in_set_c;
  logic                rep_fire_c;
  logic                inc_fire_c;

  assign set_field = state;

  // Two-flop synchronizers plus a delay flop for falling-edge detection.
  always_ff @(posedge clk_50MHz or negedge rst_n) begin
    if (!rst_n) begin
      mode_s1 <= 1'b1;
      mode_s2 <= 1'b1;
      mode_d  <= 1'b1;
      inc_s1  <= 1'b1;
      inc_s2  <= 1'b1;
      inc_d   <= 1'b1;
    end else begin
      mode_s1 <= key_mode_n;
      mode_s2 <= mode_s1;
      mode_d  <= mode_s2;
      inc_s1  <= key_inc_n;
      inc_s2  <= inc_s1;
      inc_d   <= inc_s2;
    end
  end

  assign mode_press_c = mode_d & ~mode_s2;
  assign inc_press_c  = inc_d & ~inc_s2;
  assign in_set_c     = (state != S_RUN);

  // Repeat fires only while the key is still down; release cancels a pending pulse.
  assign rep_fire_c = hold_act && !inc_s2 &&
                      (rep_phase ? (hold_cnt == HOLD_W'(REPEAT_PER - 1))
                                 : (hold_cnt == HOLD_W'(REPEAT_DLY - 1)));

  // A mode press in the same cycle swallows any inc activity.
  assign inc_fire_c = in_set_c && !mode_press_c && (inc_press_c || rep_fire_c);

  // Mode-key sequencing of the field being set.
  always_comb begin
    state_nxt = state;
    if (mode_press_c) begin
      case (state)
        S_RUN:   state_nxt = S_MIN;
        S_MIN:   state_nxt = S_HOUR;
        S_HOUR:  state_nxt = S_DAY;
        S_DAY:   state_nxt = S_MON;
        S_MON:   state_nxt = S_YEAR;
        default: state_nxt = S_RUN;
      endcase
    end
  end

  // Divider runs only while staying in RUN, so re-entering RUN restarts it at 0.
  always_comb begin
    div_nxt = '0;
    if ((state == S_RUN) && (state_nxt == S_RUN) &&
        (div_cnt != DIV_W'(DIV_1HZ - 1))) begin
      div_nxt = div_cnt + DIV_W'(1);
    end
  end

  // State, counters and registered outputs.
  always_ff @(posedge clk_50MHz or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_RUN;
      div_cnt    <= '0;
      hold_cnt   <= '0;
      hold_act   <= 1'b0;
      rep_phase  <= 1'b0;
      blink_cnt  <= '0;
      blink      <= 1'b0;
      tick_1Hz   <= 1'b0;
      clr_sec    <= 1'b0;
      inc_min_o  <= 1'b0;
      inc_hour_o <= 1'b0;
      inc_day_o  <= 1'b0;
      inc_mon_o  <= 1'b0;
      inc_year_o <= 1'b0;
    end else begin
      state    <= state_nxt;
      div_cnt  <= div_nxt;
      tick_1Hz <= (state_nxt == S_RUN) && (div_nxt == DIV_W'(DIV_1HZ - 1));
      clr_sec  <= (state == S_RUN) && (state_nxt == S_MIN);

      inc_min_o  <= inc_fire_c && (state == S_MIN);
      inc_hour_o <= inc_fire_c && (state == S_HOUR);
      inc_day_o  <= inc_fire_c && (state == S_DAY);
      inc_mon_o  <= inc_fire_c && (state == S_MON);
      inc_year_o <= inc_fire_c && (state == S_YEAR);

      // Hold tracking: armed only by an accepted press, dropped on release or mode.
      if (!in_set_c || mode_press_c || inc_s2) begin
        hold_act  <= 1'b0;
        hold_cnt  <= '0;
        rep_phase <= 1'b0;
      end else if (inc_press_c) begin
        hold_act  <= 1'b1;
        hold_cnt  <= '0;
        rep_phase <= 1'b0;
      end else if (hold_act) begin
        if (rep_fire_c) begin
          hold_cnt  <= '0;
          rep_phase <= 1'b1;
        end else begin
          hold_cnt <= hold_cnt + HOLD_W'(1);
        end
      end

      // Blink restarts low on every state change and stays low in RUN.
      if (!in_set_c || (state_nxt != state)) begin
        blink_cnt <= '0;
        blink     <= 1'b0;
      end else if (blink_cnt == BLINK_W'(BLINK_HALF - 1)) begin
        blink_cnt <= '0;
        blink     <= ~blink;
      end else begin
        blink_cnt <= blink_cnt + BLINK_W'(1);
      end
    end
  end

endmodule
